// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit RISC CPU: default widths, opcode constants
// and the fetch FSM state type.
package cpu_pkg;
    localparam int DEF_ADDR_WIDTH = 13;
    localparam int DEF_DATA_WIDTH = 16;

    localparam logic [3:0] OP_HALT = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FULL = 2'd2,
        HALT = 2'd3
    } fetch_state_t;
endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: memory read port, decode handshake and execute redirect.
// The master side is the fetch stage; the slave side is memory/decode/execute.
interface instr_fetch_if #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 16
);
    logic                  mem_read;
    logic [ADDR_WIDTH-1:0] mem_read_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  mem_rd_done;
    logic                  redirect;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  instr_valid;
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic                  instr_ready;
    logic                  halted;

    modport master (
        output mem_read, mem_read_addr, instr_valid, instr, instr_pc, halted,
        input  mem_rd_data, mem_rd_done, redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  mem_read, mem_read_addr, instr_valid, instr, instr_pc, halted,
        output mem_rd_data, mem_rd_done, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/instr_fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries; occupancy tracked with an explicit count
// register. Storage is not reset, only pointers and count.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 29
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] store_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) store_q[wr_ptr_q] <= push_data;
    end

    assign head  = store_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, single-outstanding memory read, prefetch FIFO.
// Optional halt-opcode detection is enabled by defining IFETCH_HALT_DETECT_EN.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = ADDR_WIDTH + DATA_WIDTH;

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  mem_read_q, mem_read_d;
    logic [ADDR_WIDTH-1:0] mem_read_addr_q, mem_read_addr_d;

    logic [EW-1:0] fifo_head;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count, count_after;
    logic          pop, accept, push, full_after, is_halt;

    assign pop    = !fifo_empty && bus.instr_ready;
    assign accept = (state_q == REQ) && mem_read_q && bus.mem_rd_done && !bus.redirect;
    assign push   = accept && (!fifo_full || pop);

    assign count_after = fifo_count + CW'(push) - CW'(pop);
    assign full_after  = (count_after == CW'(FIFO_DEPTH));

`ifdef IFETCH_HALT_DETECT_EN
    assign is_halt    = (bus.mem_rd_data[DATA_WIDTH-1 -: 4] == OP_HALT);
    assign bus.halted = (state_q == HALT);
`else
    assign is_halt    = 1'b0;
    assign bus.halted = 1'b0;
`endif

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.redirect),
        .push      (push),
        .push_data ({pc_q, bus.mem_rd_data}),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            pc_q            <= RESET_PC;
            mem_read_q      <= 1'b0;
            mem_read_addr_q <= RESET_PC;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            mem_read_q      <= mem_read_d;
            mem_read_addr_q <= mem_read_addr_d;
        end
    end

    // Redirect overrides every state, including FULL and HALT.
    always_comb begin
        state_d = state_q;
        if (bus.redirect) begin
            state_d = REQ;
        end else begin
            case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (accept) begin
                        if (is_halt)         state_d = HALT;
                        else if (full_after) state_d = FULL;
                        else                 state_d = REQ;
                    end
                end
                FULL:    if (pop) state_d = REQ;
                HALT:    state_d = HALT;
                default: state_d = IDLE;
            endcase
        end
    end

    // The request register tracks the next state so a new address issues on the
    // same edge that retires the previous read.
    always_comb begin
        pc_d            = pc_q;
        mem_read_d      = mem_read_q;
        mem_read_addr_d = mem_read_addr_q;
        if (bus.redirect) begin
            pc_d            = bus.redirect_pc;
            mem_read_d      = 1'b1;
            mem_read_addr_d = bus.redirect_pc;
        end else begin
            case (state_q)
                IDLE: mem_read_d = 1'b0;
                REQ: begin
                    if (accept) begin
                        pc_d            = pc_q + ADDR_WIDTH'(1);
                        mem_read_addr_d = pc_q + ADDR_WIDTH'(1);
                        mem_read_d      = (state_d == REQ);
                    end else if (!mem_read_q) begin
                        mem_read_d      = 1'b1;
                        mem_read_addr_d = pc_q;
                    end
                end
                FULL: begin
                    if (pop) begin
                        mem_read_d      = 1'b1;
                        mem_read_addr_d = pc_q;
                    end
                end
                default: mem_read_d = 1'b0;
            endcase
        end
    end

    assign bus.mem_read      = mem_read_q;
    assign bus.mem_read_addr = mem_read_addr_q;
    assign bus.instr_valid   = !fifo_empty;
    assign bus.instr         = fifo_empty ? '0 : fifo_head[DATA_WIDTH-1:0];
    assign bus.instr_pc      = fifo_empty ? '0 : fifo_head[EW-1:DATA_WIDTH];
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the 16-bit RISC CPU, sitting directly upstream of the 8K-word unified memory's read port. Holds the program counter, issues one read at a time on the memory's read/rd_done handshake, and buffers returned instruction words in a small prefetch FIFO. Decode drains the FIFO through a valid/ready handshake, and execute redirects the fetch PC on branches and jumps.

## Interface
- ADDR_WIDTH, 13, word address width; matches the memory read address.
- DATA_WIDTH, 16, instruction word width.
- FIFO_DEPTH, 4, prefetch entries; power of two, at least 2.
- RESET_PC, 0, PC loaded on reset.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_read  output  1  read request to memory; registered.
- mem_read_addr  output  ADDR_WIDTH  read address; registered, stable while mem_read is high.
- mem_rd_data  input  DATA_WIDTH  read data, valid when mem_rd_done is high.
- mem_rd_done  input  1  read completion.
- redirect  input  1  one-cycle pulse from execute: flush and refetch.
- redirect_pc  input  ADDR_WIDTH  new fetch address, sampled when redirect is high.
- instr_valid  output  1  FIFO head holds a valid instruction.
- instr  output  DATA_WIDTH  FIFO head instruction word.
- instr_pc  output  ADDR_WIDTH  address the head word was fetched from.
- instr_ready  input  1  decode accepts the head this cycle.
- halted  output  1  fetch stopped on a halt opcode (only with IFETCH_HALT_DETECT_EN; otherwise tied 0).

## Operation
- FSM states: IDLE, REQ, FULL, HALT.
- IDLE: entered only from reset. Moves to REQ on the next cycle.
- REQ: mem_read=1 with mem_read_addr=pc.
  - A read is accepted on an edge where mem_read and mem_rd_done are both 1.
  - On acceptance: push {pc, mem_rd_data} and set pc <= pc+1. The increment wraps from 2^ADDR_WIDTH-1 to 0.
  - After acceptance, stay in REQ if the FIFO will still have a free slot. The free-slot count is evaluated after this cycle's push and pop. Otherwise drop mem_read and go to FULL.
- FULL: mem_read=0. Return to REQ on the edge after a pop frees a slot.
- Pop: occurs on an edge with instr_valid && instr_ready. Push and pop in the same cycle leave the count unchanged and are legal when full, since the pop makes room first.
- Redirect has priority over everything:
  - Effects: pc <= redirect_pc; FIFO flushed (count=0, pointers reset); any response completing that same cycle is discarded; state <= REQ (including from FULL or HALT).
  - A pop in the redirect cycle is still honoured at the decode side.
- Only one request is ever outstanding. mem_read_addr never changes while mem_read is high.

## Timing
- Reset values: mem_read=0, mem_read_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, halted=0; pc=RESET_PC; FIFO empty; state IDLE.
- Reset sequence: with rst low at edge 0, mem_read goes high after edge 1.
- With a same-cycle mem_rd_done, the word is pushed at edge 2, and instr_valid is high after edge 2.
- Sustained throughput: one instruction per cycle when memory completes in the same cycle and decode holds instr_ready=1.
- instr and instr_pc come from registered FIFO storage. No combinational path from mem_rd_data to instr.
- Redirect: mem_read_addr=redirect_pc in the cycle after the pulse. instr_valid is 0 in that cycle.
- Reset mid-request abandons the read immediately. A late mem_rd_done after reset is ignored because mem_read=0.

## Configuration
- IFETCH_HALT_DETECT_EN defined:
  - A pushed word with bits [15:12]=4'b1100 is the halt opcode.
  - After it is pushed, the FSM goes to HALT: mem_read=0, halted=1.
  - Earlier FIFO entries and the halt word itself still drain to decode.
  - Only redirect or rst leaves HALT, and both clear halted.
- IFETCH_HALT_DETECT_EN undefined: no opcode inspection, the HALT state is unreachable, halted=0, and fetch runs until the FIFO fills.

## Structure
- Shared package cpu_pkg:
  - ADDR_WIDTH and DATA_WIDTH defaults.
  - OP_HALT = 4'b1100 opcode constant.
  - fetch_state_t enum {IDLE, REQ, FULL, HALT}.
- Sub-module fetch_fifo: synchronous FIFO of {pc, instr} entries.
  - Ports: push, pop, flush, full, empty, count.
  - Uses a count register rather than pointer-MSB comparison.
- The top level holds the FSM, pc, and the memory request register.

## Test plan
- Reset release with memory preloaded 0:D000, 1:D041, 2:D0C7, and same-cycle rd_done, instr_ready=1:
  - mem_read_addr steps 0,1,2.
  - instr 0xD000, 0xD041, 0xD0C7 appear on consecutive cycles with instr_pc 0,1,2.
- instr_ready=0 for 10 cycles:
  - Exactly 4 reads accepted, then mem_read=0 (FULL).
  - One pop makes mem_read rise on the next cycle with addr 4.
- redirect with redirect_pc=0x100 while the FIFO holds 3 entries and rd_done fires the same cycle:
  - FIFO empty next cycle, stale word discarded.
  - Next fetch addr 0x100; first instr_pc=0x100.
- pc=0x1FFF:
  - Fetch at 0x1FFF, then next mem_read_addr=0x0000.
- IFETCH_HALT_DETECT_EN, program with 0xC000 at addr 16:
  - Halt word delivered with instr_pc=16, halted=1, no read of addr 17.
  - A redirect to 0 clears halted and resumes fetch.
- rst asserted while mem_read=1 and rd_done withheld:
  - Next cycle mem_read=0, instr_valid=0, mem_read_addr=RESET_PC.
